// File: rtl/axi_lite_master_cmd.sv
// axi_lite_master_cmd: single-outstanding command to AXI4-Lite master bridge.
// Optional watchdog abort enabled by defining AXI_MASTER_TIMEOUT_EN.
module axi_lite_master_cmd #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);
  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, RSP} state_t;
  state_t state_q;
  logic awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q, rsp_valid_q;
  logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr_q, araddr_q;
  logic [C_M_AXI_DATA_WIDTH-1:0] wdata_q, rsp_rdata_q;
  logic [1:0] rsp_resp_q;
  logic aw_done, w_done, b_fire;
  if (C_M_AXI_DATA_WIDTH != 32 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("axi_lite_master_cmd: unsupported configuration");
  end
  assign cmd_ready     = M_AXI_ARESETN && state_q == IDLE;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;
  assign aw_done = !awvalid_q || M_AXI_AWREADY;
  assign w_done  = !wvalid_q || M_AXI_WREADY;
  // A B beat is only meaningful once both AW and W have been handed over.
  assign b_fire  = M_AXI_BVALID && (state_q == WRESP || (state_q == WADDR && aw_done && w_done));
`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
  logic [CW-1:0] cnt_q;
  logic busy, expired;
  assign busy    = state_q inside {WADDR, WRESP, RADDR, RDATA};
  assign expired = busy && cnt_q == CW'(TIMEOUT_CYCLES);
`endif
  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      state_q     <= IDLE;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
`ifdef AXI_MASTER_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
`ifdef AXI_MASTER_TIMEOUT_EN
      if (busy) cnt_q <= cnt_q + 1'b1;
`endif
      case (state_q)
        IDLE: if (cmd_valid) begin
`ifdef AXI_MASTER_TIMEOUT_EN
          cnt_q <= '0;
`endif
          if (cmd_write) begin
            state_q   <= WADDR;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            bready_q  <= 1'b1;
            awaddr_q  <= cmd_addr;
            wdata_q   <= cmd_wdata;
          end else begin
            state_q   <= RADDR;
            arvalid_q <= 1'b1;
            araddr_q  <= cmd_addr;
          end
        end
        WADDR: begin
          if (M_AXI_AWREADY) awvalid_q <= 1'b0;
          if (M_AXI_WREADY) wvalid_q <= 1'b0;
          if (aw_done && w_done) state_q <= WRESP;
        end
        WRESP: ;
        RADDR: if (M_AXI_ARREADY) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          state_q   <= RDATA;
        end
        RDATA: if (M_AXI_RVALID) begin
          rready_q    <= 1'b0;
          rsp_rdata_q <= M_AXI_RDATA;
          rsp_resp_q  <= M_AXI_RRESP;
          rsp_valid_q <= 1'b1;
          state_q     <= RSP;
        end
        RSP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (b_fire) begin
        bready_q    <= 1'b0;
        rsp_rdata_q <= '0;
        rsp_resp_q  <= M_AXI_BRESP;
        rsp_valid_q <= 1'b1;
        state_q     <= RSP;
      end
`ifdef AXI_MASTER_TIMEOUT_EN
      if (expired) begin
        awvalid_q   <= 1'b0;
        wvalid_q    <= 1'b0;
        bready_q    <= 1'b0;
        arvalid_q   <= 1'b0;
        rready_q    <= 1'b0;
        rsp_rdata_q <= '0;
        rsp_resp_q  <= 2'b11;
        rsp_valid_q <= 1'b1;
        state_q     <= RSP;
      end
`endif
    end
  end
endmodule

// File: tb/tb_axi_lite_master_cmd.sv
// tb_axi_lite_master_cmd: directed stimulus with a response scoreboard for axi_lite_master_cmd.
module tb_axi_lite_master_cmd;
  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  int n_cmp = 0;
  int n_bad = 0;
  logic [33:0] exp_q[$];

  always #5 clk = ~clk;

  axi_lite_master_cmd #(.C_M_AXI_DATA_WIDTH(32), .C_M_AXI_ADDR_WIDTH(4), .TIMEOUT_CYCLES(16)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rstn && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", {rsp_resp, rsp_rdata[29:0]}, 32'hffff_ffff);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e[31:0]);
        chk("rsp_resp", {30'd0, rsp_resp}, {30'd0, e[33:32]});
      end
    end
  end

  task automatic issue(input logic wr, input logic [3:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    smp();
    chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    cyc();
    cmd_valid = 1'b0;
    cmd_addr  = ~a;
    cmd_wdata = ~d;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input int aw_lat, input int w_lat, input logic [1:0] br);
    int last;
    last = aw_lat > w_lat ? aw_lat : w_lat;
    exp_q.push_back({br, 32'd0});
    issue(1'b1, a, d);
    for (int k = 0; k <= last; k++) begin
      awready = (k == aw_lat);
      wready  = (k == w_lat);
      smp();
      chk("awvalid", {31'd0, awvalid}, {31'd0, k <= aw_lat});
      chk("wvalid", {31'd0, wvalid}, {31'd0, k <= w_lat});
      chk("bready_waddr", {31'd0, bready}, 32'd1);
      if (k == 0) begin
        chk("awaddr", {28'd0, awaddr}, {28'd0, a});
        chk("wdata", wdata, d);
        chk("wstrb_prot", {25'd0, wstrb, awprot}, {25'd0, 4'hf, 3'b000});
      end
      cyc();
    end
    awready = 1'b0;
    wready  = 1'b0;
    smp();
    chk("valids_dropped", {30'd0, awvalid, wvalid}, 32'd0);
    chk("bready_wresp", {31'd0, bready}, 32'd1);
    bvalid = 1'b1;
    bresp  = br;
    cyc();
    bvalid = 1'b0;
    bresp  = 2'b00;
    smp();
    chk("rsp_valid_after_b", {31'd0, rsp_valid}, 32'd1);
    chk("bready_rsp", {31'd0, bready}, 32'd0);
    cyc();
    smp();
    chk("cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
    cyc();
  endtask

  task automatic do_read(input logic [3:0] a, input logic [31:0] d, input logic [1:0] rr, input int ar_lat, input int r_lat, input bit hold);
    exp_q.push_back({rr, d});
    issue(1'b0, a, 32'h0);
    for (int k = 0; k <= ar_lat; k++) begin
      arready = (k == ar_lat);
      smp();
      chk("arvalid", {31'd0, arvalid}, 32'd1);
      chk("rready_raddr", {31'd0, rready}, 32'd0);
      chk("araddr", {28'd0, araddr}, {28'd0, a});
      chk("no_aw_on_read", {30'd0, awvalid, wvalid}, 32'd0);
      cyc();
    end
    arready = 1'b0;
    for (int j = 0; j < r_lat; j++) begin
      smp();
      chk("rready_wait", {30'd0, rready, arvalid}, 32'd2);
      cyc();
    end
    rvalid = 1'b1;
    rdata  = d;
    rresp  = rr;
    if (hold) rsp_ready = 1'b0;
    smp();
    chk("rready_rdata", {31'd0, rready}, 32'd1);
    cyc();
    rvalid = 1'b0;
    rdata  = 32'h5555_aaaa;
    rresp  = 2'b00;
    if (!hold) begin
      smp();
      chk("rsp_valid_after_r", {30'd0, rsp_valid, rready}, 32'd2);
      cyc();
      smp();
      chk("cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
      cyc();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rstn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b1;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    repeat (3) cyc();
    smp();
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_valids", {26'd0, awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 32'd0);
    chk("rst_rsp", {rsp_resp, rsp_rdata[29:0]}, 32'd0);
    cyc();
    rstn = 1'b1;
    smp();
    chk("cmd_ready_after_rst", {31'd0, cmd_ready}, 32'd1);
    cyc();
    do_write(4'h4, 32'hdead_beef, 1, 1, 2'b00);
    do_read(4'h8, 32'h1234_5678, 2'b00, 0, 1, 1'b0);
    do_write(4'h0, 32'ha5a5_5a5a, 0, 0, 2'b00);
    do_write(4'hc, 32'h0102_0304, 2, 0, 2'b01);
    do_write(4'h4, 32'h8765_4321, 0, 3, 2'b00);
    do_read(4'h4, 32'hcafe_f00d, 2'b10, 2, 0, 1'b0);
    do_read(4'h0, 32'h0bad_f00d, 2'b00, 0, 0, 1'b1);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'hc; cmd_wdata = 32'h1111_2222;
    for (int i = 0; i < 5; i++) begin
      smp();
      chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_rsp_rdata", rsp_rdata, 32'h0bad_f00d);
      chk("hold_no_accept", {29'd0, cmd_ready, awvalid, arvalid}, 32'd0);
      cyc();
    end
    rsp_ready = 1'b1;
    exp_q.push_back({2'b10, 32'd0});
    smp();
    cyc();
    smp();
    chk("cmd_ready_after_rsp", {31'd0, cmd_ready}, 32'd1);
    cyc();
    cmd_valid = 1'b0;
    smp();
    chk("next_cmd_awvalid", {30'd0, awvalid, wvalid}, 32'd3);
    chk("next_cmd_awaddr", {28'd0, awaddr}, 32'hc);
    awready = 1'b1; wready = 1'b1;
    cyc();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bresp = 2'b10;
    cyc();
    bvalid = 1'b0; bresp = 2'b00;
    cyc();
    smp();
    chk("idle_after_hold", {31'd0, cmd_ready}, 32'd1);
    cyc();
`ifdef AXI_MASTER_TIMEOUT_EN
    exp_q.push_back({2'b11, 32'd0});
    issue(1'b1, 4'h8, 32'h7777_7777);
    n = 0;
    while (n < 40) begin
      smp();
      if (rsp_valid) break;
      cyc();
      n++;
    end
    chk("timeout_cycles", n, 17);
    chk("timeout_valids", {29'd0, awvalid, wvalid, bready}, 32'd0);
    cyc();
    smp();
    chk("idle_after_timeout", {31'd0, cmd_ready}, 32'd1);
    cyc();
`else
    issue(1'b1, 4'h8, 32'h7777_7777);
    repeat (100) cyc();
    smp();
    chk("stall_awvalid", {30'd0, awvalid, wvalid}, 32'd3);
    chk("stall_no_rsp", {31'd0, rsp_valid}, 32'd0);
    cyc();
    rstn = 1'b0;
    cyc();
    smp();
    chk("midrst_valids", {26'd0, awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 32'd0);
    chk("midrst_regs", wdata | {28'd0, awaddr}, 32'd0);
    chk("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    cyc();
    rstn = 1'b1;
    smp();
    chk("cmd_ready_after_midrst", {31'd0, cmd_ready}, 32'd1);
    cyc();
`endif
    issue(1'b1, 4'h4, 32'h3333_4444);
    repeat (3) cyc();
    rstn = 1'b0;
    cyc();
    smp();
    chk("rst_pulse_valids", {26'd0, awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 32'd0);
    chk("rst_pulse_regs", wdata | {28'd0, awaddr} | {28'd0, araddr}, 32'd0);
    cyc();
    rstn = 1'b1;
    smp();
    chk("rst_pulse_idle", {31'd0, cmd_ready}, 32'd1);
    cyc();
    do_write(4'h8, 32'h0f0f_f0f0, 1, 2, 2'b00);
    repeat (2) cyc();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/axi_lite_master_cmd.md
AXI_LITE_MASTER_CMD -- requirements
Module: axi_lite_master_cmd
Interface
REQ-001 C_M_AXI_DATA_WIDTH, default 32: data width of the AXI4-Lite bus and command path; only 32 is supported.
REQ-002 C_M_AXI_ADDR_WIDTH, default 4: address width of the AXI4-Lite bus and command path.
REQ-003 TIMEOUT_CYCLES, default 1024: watchdog limit in clocks; used only with the REQ-045 macro defined.
REQ-004 M_AXI_ACLK  in  1  the single clock; all logic is on its rising edge.
REQ-005 M_AXI_ARESETN  in  1  reset, synchronous, active-low.
REQ-006 cmd_valid  in  1  command present.
REQ-007 cmd_ready  out  1  command accepted while cmd_valid && cmd_ready.
REQ-008 cmd_write  in  1  1 = write, 0 = read.
REQ-009 cmd_addr  in  ADDR_WIDTH  byte address.
REQ-010 cmd_wdata  in  DATA_WIDTH  write data; ignored for reads.
REQ-011 rsp_valid  out  1  response present.
REQ-012 rsp_ready  in  1  response consumed while rsp_valid && rsp_ready.
REQ-013 rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
REQ-014 rsp_resp  out  2  AXI response code, or 2'b11 on timeout.
REQ-015 M_AXI_AWADDR  out  ADDR_WIDTH  write address.
REQ-016 M_AXI_AWPROT  out  3  constant 3'b000.
REQ-017 M_AXI_AWVALID  out  1  write address valid.
REQ-018 M_AXI_AWREADY  in  1  write address ready.
REQ-019 M_AXI_WDATA  out  DATA_WIDTH  write data.
REQ-020 M_AXI_WSTRB  out  DATA_WIDTH/8  constant all-ones.
REQ-021 M_AXI_WVALID  out  1  write data valid.
REQ-022 M_AXI_WREADY  in  1  write data ready.
REQ-023 M_AXI_BRESP  in  2  write response.
REQ-024 M_AXI_BVALID  in  1  write response valid.
REQ-025 M_AXI_BREADY  out  1  write response ready.
REQ-026 M_AXI_ARADDR  out  ADDR_WIDTH  read address.
REQ-027 M_AXI_ARPROT  out  3  constant 3'b000.
REQ-028 M_AXI_ARVALID  out  1  read address valid.
REQ-029 M_AXI_ARREADY  in  1  read address ready.
REQ-030 M_AXI_RDATA  in  DATA_WIDTH  read data.
REQ-031 M_AXI_RRESP  in  2  read response.
REQ-032 M_AXI_RVALID  in  1  read data valid.
REQ-033 M_AXI_RREADY  out  1  read data ready.
Function
REQ-034 FSM states are IDLE, WADDR, WRESP, RADDR, RDATA and RSP; cmd_ready is a combinational decode equal to 1 only in IDLE, and at most one transaction is outstanding.
REQ-035 A write command accepted in IDLE latches cmd_addr/cmd_wdata and goes to WADDR; AWVALID and WVALID assert together on the next cycle, so the downstream slave sees both valids in the same cycle.
REQ-036 In WADDR, AWVALID and WVALID each hold until their own handshake and then drop independently; the block goes to WRESP when both handshakes are done, including the case where both complete in the same cycle.
REQ-037 BREADY is 1 in WADDR and WRESP; on the BVALID && BREADY cycle, rsp_resp is set to BRESP, rsp_rdata to 0, and the state goes to RSP.
REQ-038 A read command accepted in IDLE latches cmd_addr and goes to RADDR; ARVALID asserts on the next cycle and holds until ARREADY, then the state goes to RDATA.
REQ-039 RREADY is 1 only in RDATA; on the RVALID cycle, rsp_rdata is set to RDATA, rsp_resp to RRESP, and the state goes to RSP.
REQ-040 rsp_valid is registered and equals 1 only in RSP; rsp_rdata and rsp_resp stay stable until rsp_ready, and the state then returns to IDLE, so cmd_ready rises in the cycle after the response handshake.
REQ-041 AXI VALID and READY signals never assert outside the states that own them (REQ-035 to REQ-039), and AXI inputs are ignored in IDLE and RSP.
Reset
REQ-042 While M_AXI_ARESETN=0 at a clock edge, including mid-transaction, the state goes to IDLE and every registered output clears to 0: all AXI VALID/READY outputs, AWADDR, ARADDR, WDATA, rsp_valid, rsp_rdata, rsp_resp and the watchdog counter; cmd_ready is 0 during reset and 1 on the first cycle after release.
Configuration
REQ-043 With AXI_MASTER_TIMEOUT_EN defined, a counter clears on command accept and increments in WADDR, WRESP, RADDR and RDATA.
REQ-044 With AXI_MASTER_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES, all AXI VALID/READY outputs drop the next cycle, the state goes to RSP with rsp_resp=2'b11 and rsp_rdata=0, and this forced abort is an accepted debug recovery.
REQ-045 With AXI_MASTER_TIMEOUT_EN undefined, the counter is absent and the block waits indefinitely.
Verification
REQ-046 Write 0xDEADBEEF to address 0x4, with the slave raising AWREADY/WREADY one cycle after both valids -> AWADDR=0x4, WDATA=0xDEADBEEF, both valids rise in the same cycle, rsp_valid rises 1 cycle after the B handshake with rsp_resp=00 and rsp_rdata=0.
REQ-047 Read address 0x8, with the slave returning 0x12345678 and RRESP=00 -> ARADDR=0x8, then rsp_rdata=0x12345678 and rsp_resp=00; AWREADY in the same cycle as WREADY, and in separate cycles, both give a correct write response.
REQ-048 Hold rsp_ready=0 for 5 cycles while cmd_valid=1 -> rsp_valid and rsp_rdata are stable, cmd_ready=0 and no new AXI valid appears; the next command is accepted in the cycle after rsp_ready rises.
REQ-049 With the macro defined, TIMEOUT_CYCLES=16 and a slave that never responds -> valids drop and rsp_resp=11 after 16 cycles; with the macro undefined, AWVALID is still 1 after 100 cycles; a reset pulse in WADDR -> all outputs 0 and the state back to IDLE.
